mux_tree_pipe: RTL and testbench

Parametrised N:1 stream multiplexer built as a log2(N)-level tree of 2:1 muxes with per-level pipeline registers and valid/ready flow control. Successor to the fixed 4-bit 4:1 combinational mux: arbitrary power-of-two input count and data width, registered output, backpressure, and a tag of the selected channel travelling with the data. Sits between a bank of N same-width sources and a single consumer.

---
 rtl/mux_tree_pipe_pkg.sv | 12 +
 rtl/mux_tree_pipe_if.sv | 31 +++
 rtl/mux_tree_pipe_stage.sv | 65 ++++++
 rtl/mux_tree_pipe.sv | 104 ++++++++++
 tb/tb_mux_tree_pipe.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared defaults and elaboration helpers for the mux_tree_pipe block.
package mux_tree_pkg;

    localparam int MUX_TREE_N_DEFAULT = 8;
    localparam int MUX_TREE_W_DEFAULT = 4;

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Stream bundle between the N source channels, the mux tree and its consumer.
// The slave modport is the mux tree's view; the master modport is the
// view of the logic that feeds the sources and consumes the output.
interface mux_tree_pipe_if
    import mux_tree_pkg::*;
#(
    parameter int N = MUX_TREE_N_DEFAULT,
    parameter int W = MUX_TREE_W_DEFAULT
);
    localparam int S = $clog2(N);

    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] d;
    logic [S-1:0]        sel;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        y;
    logic [S-1:0]        y_sel;

    modport master (
        output in_valid, d, sel, out_ready,
        input  in_ready, out_valid, y, y_sel
    );

    modport slave (
        input  in_valid, d, sel, out_ready,
        output in_ready, out_valid, y, y_sel
    );

endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One registered slice of the mux tree. It resolves LEVELS consecutive
// 2:1 tree levels combinationally, starting at select bit BIT, and then
// holds the surviving words, the full select tag and a valid flag in a
// single handshake register. LEVELS = 1 gives one pipelined tree level;
// LEVELS = S collapses the whole tree in front of one output register.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int W      = MUX_TREE_W_DEFAULT,
    parameter int S      = 1,
    parameter int BIT    = 0,
    parameter int LEVELS = 1
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_IN-1:0][W-1:0]               in_data,
    input  logic [S-1:0]                         in_sel,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [(N_IN >> LEVELS)-1:0][W-1:0]   out_data,
    output logic [S-1:0]                         out_sel
);
    localparam int N_OUT = N_IN >> LEVELS;

    logic [N_IN-1:0][W-1:0]  work;
    logic [N_OUT-1:0][W-1:0] next_data;
    logic                    valid_q;

    // Halve the candidate set once per level: pair (2j, 2j+1) -> j, odd on a
    // select bit of 1. Only the chosen operand is copied, so unknowns on the
    // discarded side never reach the result.
    always_comb begin
        work = in_data;
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < (N_IN >> (l + 1)); j++) begin
                work[j] = in_sel[BIT + l] ? work[2*j + 1] : work[2*j];
            end
        end
        next_data = work[N_OUT-1:0];
    end

    // The slot can take a new beat when empty or when its beat leaves now.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    // Handshake register: load on ready, clear valid when drained with
    // nothing incoming, keep data untouched on bubbles so the output is quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_data <= next_data;
                out_sel  <= in_sel;
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// N:1 stream multiplexer built as a tree of 2:1 muxes with valid/ready flow
// control and the selecting channel index carried alongside the data.
// Build option MUX_TREE_PIPE_LEVEL_REGS_EN: when defined, every tree level is
// registered (S stages, latency S); otherwise the tree is combinational in
// front of a single output register (latency 1).
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int N = MUX_TREE_N_DEFAULT,
    parameter int W = MUX_TREE_W_DEFAULT
)(
    input  logic           clk,
    input  logic           rst,
    mux_tree_pipe_if.slave bus
);
    localparam int S = $clog2(N);

    if ((N < 2) || !is_pow2(N)) begin : g_bad_n
        $error("mux_tree_pipe: N must be a power of two and at least 2");
    end

`ifdef MUX_TREE_PIPE_LEVEL_REGS_EN

    // One registered stage per select bit; each level links to its
    // neighbours by name so the ready chain stays a plain series of gates.
    for (genvar k = 0; k < S; k++) begin : g_level
        localparam int NI = N >> k;
        localparam int NO = NI / 2;

        logic [NI-1:0][W-1:0] i_data;
        logic [S-1:0]         i_sel;
        logic                 i_valid;
        logic                 i_ready;
        logic [NO-1:0][W-1:0] o_data;
        logic [S-1:0]         o_sel;
        logic                 o_valid;
        logic                 o_ready;

        if (k == 0) begin : g_head
            assign i_data  = bus.d;
            assign i_sel   = bus.sel;
            assign i_valid = bus.in_valid;
        end else begin : g_link
            assign i_data  = g_level[k-1].o_data;
            assign i_sel   = g_level[k-1].o_sel;
            assign i_valid = g_level[k-1].o_valid;
        end

        if (k == S - 1) begin : g_tail
            assign o_ready = bus.out_ready;
        end else begin : g_fwd
            assign o_ready = g_level[k+1].i_ready;
        end

        mux_tree_stage #(
            .N_IN   (NI),
            .W      (W),
            .S      (S),
            .BIT    (k),
            .LEVELS (1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (i_valid),
            .in_ready  (i_ready),
            .in_data   (i_data),
            .in_sel    (i_sel),
            .out_valid (o_valid),
            .out_ready (o_ready),
            .out_data  (o_data),
            .out_sel   (o_sel)
        );
    end

    assign bus.in_ready  = g_level[0].i_ready;
    assign bus.out_valid = g_level[S-1].o_valid;
    assign bus.y         = g_level[S-1].o_data;
    assign bus.y_sel     = g_level[S-1].o_sel;

`else

    // Whole tree resolved in one combinational slice ahead of one register.
    mux_tree_stage #(
        .N_IN   (N),
        .W      (W),
        .S      (S),
        .BIT    (0),
        .LEVELS (S)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (bus.d),
        .in_sel    (bus.sel),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.y),
        .out_sel   (bus.y_sel)
    );

`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: an 8x4 instance driven through
// directed and random sequences, plus a 2x1 instance for the smallest tree.
module tb_mux_tree_pipe;
    localparam int N = 8;
    localparam int W = 4;
    localparam int S = $clog2(N);
`ifdef MUX_TREE_PIPE_LEVEL_REGS_EN
    localparam int LAT = S;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT;
    localparam int LAT2  = 1;

    typedef struct {
        logic [W-1:0] y;
        logic [S-1:0] s;
        int           acc;
        bit           lat;
    } exp_t;

    typedef struct {
        logic y;
        logic s;
        int   acc;
        bit   lat;
    } exp2_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    mode = 0;
    exp_t  q[$];
    exp2_t q2[$];

    mux_tree_pipe_if #(.N(N), .W(W)) bus ();
    mux_tree_pipe_if #(.N(2), .W(1)) bus2 ();

    mux_tree_pipe #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux_tree_pipe #(.N(2), .W(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one beat to the 8-channel instance; the expected word is simply
    // channel s of the offered data. Leaves in_valid high if never accepted.
    task automatic applyStimulus(input logic [S-1:0] s, input logic [N-1:0][W-1:0] dv,
                                 input int maxCycles, input bit lat, output bit ok);
        bus.in_valid = 1'b1;
        bus.d        = dv;
        bus.sel      = s;
        ok           = 1'b0;
        for (int c = 0; c < maxCycles && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{y: dv[s], s: s, acc: cyc + 1, lat: lat});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (ok) bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus2(input logic s, input logic [1:0][0:0] dv, output bit ok);
        bus2.in_valid = 1'b1;
        bus2.d        = dv;
        bus2.sel      = s;
        ok            = 1'b0;
        for (int c = 0; c < 4 && !ok; c++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                q2.push_back('{y: dv[s], s: s, acc: cyc + 1, lat: 1'b1});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
    endtask

    task automatic drain(input int maxCycles);
        int c = 0;
        while ((q.size() != 0 || q2.size() != 0) && c < maxCycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drain_leftover", 32'(q.size() + q2.size()), 0);
    endtask

    // Consumer: out_ready pattern chosen by mode (1, 0, toggling, random).
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor for the 8-channel instance: every presented beat must match the
    // oldest outstanding expectation; it is retired only when consumed.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
            checkOutput("rst_y", 32'(bus.y), 0);
            checkOutput("rst_y_sel", 32'(bus.y_sel), 0);
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                checkOutput("spurious_beat", 32'(bus.out_valid), 0);
            end else begin
                checkOutput("y", 32'(bus.y), 32'(q[0].y));
                checkOutput("y_sel", 32'(bus.y_sel), 32'(q[0].s));
                if (q[0].lat) begin
                    checkOutput("latency", 32'(cyc - q[0].acc + 1), LAT);
                    q[0].lat = 1'b0;
                end
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    // Monitor for the 2-channel instance.
    always @(negedge clk) begin
        if (!rst && bus2.out_valid) begin
            if (q2.size() == 0) begin
                checkOutput("n2_spurious_beat", 32'(bus2.out_valid), 0);
            end else begin
                checkOutput("n2_y", 32'(bus2.y), 32'(q2[0].y));
                checkOutput("n2_y_sel", 32'(bus2.y_sel), 32'(q2[0].s));
                if (q2[0].lat) begin
                    checkOutput("n2_latency", 32'(cyc - q2[0].acc + 1), LAT2);
                    q2[0].lat = 1'b0;
                end
                if (bus2.out_ready) void'(q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0][W-1:0] dv;
        logic [N-1:0][W-1:0] bp_data [3];
        logic [S-1:0]        bp_sel [3];
        logic [1:0][0:0]     dv2;
        bit                  ok;
        int                  cnt;

        bus.in_valid   = 1'b0;
        bus.d          = '0;
        bus.sel        = '0;
        bus2.in_valid  = 1'b0;
        bus2.d         = '0;
        bus2.sel       = '0;
        bus2.out_ready = 1'b1;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(bus.in_ready), 1);
        checkOutput("idle_out_valid", 32'(bus.out_valid), 0);
        checkOutput("idle_y", 32'(bus.y), 0);
        @(posedge clk);
        #1;

        $display("[TB] sweep sel 0..7 back to back");
        for (int i = 0; i < N; i++) dv[i] = W'(i + 8);
        for (int s = 0; s < N; s++) begin
            applyStimulus(S'(s), dv, 1, (s == 0), ok);
            checkOutput("sweep_accept", 32'(ok), 1);
        end
        drain(40);

        $display("[TB] unknown on unselected channel");
        for (int i = 0; i < N; i++) dv[i] = W'(5);
        dv[3] = 'x;
        applyStimulus(S'(2), dv, 4, 1'b0, ok);
        applyStimulus(S'(3), dv, 4, 1'b0, ok);
        drain(40);

        $display("[TB] backpressure fill and release");
        mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        bp_sel[0] = S'(1);
        bp_sel[1] = S'(4);
        bp_sel[2] = S'(6);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < N; i++) bp_data[b][i] = W'($urandom);
        cnt = 0;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(bp_sel[b], bp_data[b], 2, 1'b0, ok);
            if (!ok) break;
            cnt++;
        end
        checkOutput("bp_accepted", 32'(cnt), (DEPTH < 3) ? DEPTH : 3);
        @(negedge clk);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 0);
        repeat (4) begin @(posedge clk); #1; end
        mode = 0;
        for (int b = cnt; b < 3; b++) begin
            applyStimulus(bp_sel[b], bp_data[b], 20, 1'b0, ok);
            checkOutput("bp_resume_accept", 32'(ok), 1);
        end
        drain(40);

        $display("[TB] push and pop on a full pipeline");
        mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        for (int b = 0; b < DEPTH; b++) begin
            for (int i = 0; i < N; i++) dv[i] = W'($urandom);
            applyStimulus(S'($urandom_range(0, N - 1)), dv, 1, 1'b0, ok);
            checkOutput("full_fill_accept", 32'(ok), 1);
        end
        mode = 2;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < N; i++) dv[i] = W'($urandom);
            applyStimulus(S'($urandom_range(0, N - 1)), dv, 4, 1'b0, ok);
            checkOutput("toggle_accept", 32'(ok), 1);
        end
        mode = 0;
        drain(40);

        $display("[TB] reset with beats in flight");
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) dv[i] = W'($urandom);
            applyStimulus(S'($urandom_range(0, N - 1)), dv, 1, 1'b0, ok);
        end
        rst = 1'b1;
        q.delete();
        q2.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("post_rst_out_valid", 32'(bus.out_valid), 0);
            checkOutput("post_rst_y", 32'(bus.y), 0);
            checkOutput("post_rst_y_sel", 32'(bus.y_sel), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) dv[i] = W'($urandom);
        applyStimulus(S'(5), dv, 1, 1'b1, ok);
        checkOutput("post_rst_accept", 32'(ok), 1);
        drain(40);

        $display("[TB] two-channel instance");
        for (int b = 0; b < 6; b++) begin
            dv2[0] = 1'($urandom);
            dv2[1] = 1'($urandom);
            applyStimulus2(1'(b % 2), dv2, ok);
            checkOutput("n2_accept", 32'(ok), 1);
            repeat (2) begin @(posedge clk); #1; end
        end
        drain(20);

        $display("[TB] random traffic with random consumer");
        mode = 3;
        for (int b = 0; b < 60; b++) begin
            for (int i = 0; i < N; i++) dv[i] = W'($urandom);
            applyStimulus(S'($urandom_range(0, N - 1)), dv, 50, 1'b0, ok);
            checkOutput("rand_accept", 32'(ok), 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        mode = 0;
        drain(100);

        @(negedge clk);
        checkOutput("final_out_valid", 32'(bus.out_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
